// File: rtl/final_soc_pio_in_irq.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture, IRQ mask and one IRQ line.
// Optional per-bit debounce between synchroniser and data register: define FINAL_SOC_PIO_DEBOUNCE_EN.
module final_soc_pio_in_irq #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_MODE        = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] irq_src;
  logic [31:0]      rd_next;
  logic             wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef FINAL_SOC_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt [WIDTH];
  logic [WIDTH-1:0] data_q;

  // A bit only moves once the synced value has disagreed for DEBOUNCE_CYCLES clocks in a row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[SYNC_STAGES-1][i] != data_q[i]) begin
          if (db_cnt[i] == CNT_LAST) begin
            data_q[i] <= sync_q[SYNC_STAGES-1][i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign data = data_q;
`else
  assign data = sync_q[SYNC_STAGES-1];
`endif

  assign wr_en    = chipselect & ~write_n;
  assign clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign irq_src  = (IRQ_MODE == 0) ? data : edgecapture;

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = data & ~data_d;
      1:       edge_det = ~data & data_d;
      default: edge_det = data ^ data_d;
    endcase
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = data;
      2'd2:    rd_next[WIDTH-1:0] = irqmask;
      2'd3:    rd_next[WIDTH-1:0] = edgecapture;
      default: rd_next = '0;
    endcase
  end

  // Set has priority over write-one-to-clear so an edge arriving with the clear is not lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_d      <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      data_d      <= data;
      edgecapture <= (edgecapture & ~clr_mask) | edge_det;
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      readdata    <= rd_next;
      irq         <= |(irq_src & irqmask);
    end
  end

endmodule

// File: tb/tb_final_soc_pio_in_irq.sv
// Self-checking bench for final_soc_pio_in_irq: edge-mode DUT plus a level-mode DUT on a shared bus.
// Read expectations go through a scoreboard queue and are compared when readdata is valid.
module tb_final_soc_pio_in_irq;

  localparam int SYNC = 2;
`ifdef FINAL_SOC_PIO_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int DATA_LAT = SYNC + DB;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_entry_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] readdata_lvl;
  logic        irq_lvl;

  sb_entry_t sb[$];
  int        checks = 0;
  int        errors = 0;

  final_soc_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .IRQ_MODE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  final_soc_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .IRQ_MODE(0)) dut_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_lvl), .irq(irq_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    in_port = v;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] a, input logic [31:0] exp, input string tag);
    sb_entry_t e;
    e.tag = tag;
    e.val = exp;
    sb.push_back(e);
    address    = a;
    chipselect = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    e = sb.pop_front();
    checkOutput(e.tag, readdata, e.val);
  endtask

  initial begin
    logic [7:0] pats [6];
    logic [7:0] prev;
    logic [7:0] ec_model;

    reset_n    = 1'b0;
    in_port    = '0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset values
    waitCycles(3);
    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    checkOutput("rst_irq_lvl", {31'b0, irq_lvl}, 32'h0);
    reset_n = 1'b1;
    waitCycles(1);
    for (int a = 0; a < 4; a++) readReg(2'(a), 32'h0, $sformatf("post_rst_addr%0d", a));

    // Synchronised data, rising capture, register access rules
    applyStimulus(8'h05);
    waitCycles(DATA_LAT);
    readReg(2'd0, 32'h5, "data_05");
    checkOutput("lvl_data_05", readdata_lvl, 32'h5);
    readReg(2'd3, 32'h5, "ec_rise_05");
    checkOutput("irq_unmasked", {31'b0, irq}, 32'h0);
    writeReg(2'd0, 32'hFF);
    readReg(2'd0, 32'h5, "data_readonly");
    writeReg(2'd1, 32'hFF);
    readReg(2'd1, 32'h0, "direction_zero");
    writeReg(2'd3, 32'h0);
    readReg(2'd3, 32'h5, "ec_write0_keeps");
    writeReg(2'd3, 32'h4);
    readReg(2'd3, 32'h1, "ec_w1c_partial");
    writeReg(2'd3, 32'hFFFF_FFFF);
    readReg(2'd3, 32'h0, "ec_clear_all");

    // Falling edges are not captured with rising-edge detection
    applyStimulus(8'h00);
    waitCycles(DATA_LAT + 2);
    readReg(2'd3, 32'h0, "ec_no_fall");
    readReg(2'd0, 32'h0, "data_00");

    // Masked edge raises irq; W1C drops it one cycle after the write
    writeReg(2'd2, 32'hFFFF_FF01);
    readReg(2'd2, 32'h1, "mask_upper_zero");
    applyStimulus(8'h01);
    waitCycles(DATA_LAT + 1);
    applyStimulus(8'h00);
    waitCycles(1);
    checkOutput("irq_edge_bit0", {31'b0, irq}, 32'h1);
    readReg(2'd3, 32'h1, "ec_bit0");
    writeReg(2'd3, 32'h1);
    checkOutput("irq_at_clear_write", {31'b0, irq}, 32'h1);
    waitCycles(1);
    checkOutput("irq_dropped", {31'b0, irq}, 32'h0);
    waitCycles(DATA_LAT + 2);

    // Edge on bit 3 in the same cycle as its W1C: the set must win
    applyStimulus(8'h08);
    waitCycles(DATA_LAT);
    writeReg(2'd3, 32'h8);
    readReg(2'd3, 32'h8, "ec_set_wins");
    checkOutput("irq_bit3_masked_off", {31'b0, irq}, 32'h0);
    writeReg(2'd2, 32'h8);
    waitCycles(1);
    checkOutput("irq_bit3_enabled", {31'b0, irq}, 32'h1);
    writeReg(2'd3, 32'h8);
    waitCycles(1);
    checkOutput("irq_bit3_cleared", {31'b0, irq}, 32'h0);
    readReg(2'd3, 32'h0, "ec_bit3_cleared");

    // Level-mode irq follows masked data
    writeReg(2'd2, 32'h80);
    applyStimulus(8'h00);
    waitCycles(DATA_LAT + 2);
    checkOutput("lvl_irq_low", {31'b0, irq_lvl}, 32'h0);
    applyStimulus(8'h80);
    waitCycles(DATA_LAT + 1);
    checkOutput("lvl_irq_high", {31'b0, irq_lvl}, 32'h1);
    applyStimulus(8'h00);
    waitCycles(DATA_LAT + 1);
    checkOutput("lvl_irq_back_low", {31'b0, irq_lvl}, 32'h0);
    checkOutput("edge_irq_bit7_sticky", {31'b0, irq}, 32'h1);
    writeReg(2'd3, 32'hFF);

    // Pattern sweep against a rising-edge accumulation model
    writeReg(2'd2, 32'hFF);
    pats[0] = 8'h3C;
    pats[1] = 8'hC3;
    pats[2] = 8'hFF;
    pats[3] = 8'($urandom);
    pats[4] = 8'h5A;
    pats[5] = 8'h00;
    prev     = 8'h00;
    ec_model = 8'h00;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(pats[i]);
      waitCycles(DATA_LAT + 2);
      ec_model = ec_model | (pats[i] & ~prev);
      prev     = pats[i];
      readReg(2'd0, {24'b0, pats[i]}, $sformatf("sweep_data_%0d", i));
      readReg(2'd3, {24'b0, ec_model}, $sformatf("sweep_ec_%0d", i));
      checkOutput($sformatf("sweep_irq_%0d", i), {31'b0, irq}, {31'b0, (ec_model != 8'h00)});
    end
    writeReg(2'd3, 32'hFF);
    waitCycles(1);

    // Reset mid-operation with input held high through it
    applyStimulus(8'h01);
    waitCycles(DATA_LAT + 2);
    checkOutput("pre_reset_irq", {31'b0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_irq", {31'b0, irq}, 32'h0);
    checkOutput("async_reset_readdata", readdata, 32'h0);
    waitCycles(3);
    reset_n = 1'b1;
    readReg(2'd2, 32'h0, "reset_mask_cleared");
    waitCycles(DATA_LAT + 2);
    readReg(2'd3, 32'h1, "held_high_rise_after_reset");
    checkOutput("irq_after_reset_masked", {31'b0, irq}, 32'h0);
    applyStimulus(8'h00);
    waitCycles(DATA_LAT + 2);
    writeReg(2'd3, 32'hFF);

`ifdef FINAL_SOC_PIO_DEBOUNCE_EN
    // Short glitch is rejected, long hold is accepted
    applyStimulus(8'h04);
    waitCycles(5);
    applyStimulus(8'h00);
    waitCycles(DATA_LAT + 5);
    readReg(2'd0, 32'h0, "db_glitch_data");
    readReg(2'd3, 32'h0, "db_glitch_ec");
    applyStimulus(8'h04);
    waitCycles(20);
    readReg(2'd0, 32'h4, "db_hold_data");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
